// File: rtl/cache_mem_pkg.sv
// ----------------------------------------------------------------------------
// cache_mem_pkg
// Shared types and constants for the cache backing-store responder.
//   ADDR_W / DATA_W : word address and data widths seen by the cache
//   state_t         : responder FSM states (IDLE, WAIT)
//   wb_entry_t      : one write-back buffer slot {addr, data}
//   fill_word()     : power-on / reset contents of an array word
// ----------------------------------------------------------------------------
package cache_mem_pkg;

   localparam int ADDR_W    = 5;
   localparam int DATA_W    = 3;
   localparam int MEM_WORDS = 1 << ADDR_W;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   // The cache fills a missing word with its tag bits, so the backing array
   // comes out of reset holding the same pattern: mem[a] = a[4:2].
   function automatic logic [DATA_W-1:0] fill_word(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1:2];
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// ----------------------------------------------------------------------------
// wb_fifo
// Write-back buffer: a small FIFO of {addr, data} entries with a
// combinational address search that returns the newest matching entry.
// Ports:
//   clock, reset_n   : clock and synchronous active-low reset
//   push, push_entry : enqueue an entry at the tail (caller guarantees !full)
//   pop              : retire the head entry (caller guarantees !empty)
//   head             : current head entry
//   full, empty      : occupancy flags
//   count            : number of occupied entries
//   search_addr      : address to look up
//   hit, hit_data    : a live entry matches; data of the newest such entry
// ----------------------------------------------------------------------------
module wb_fifo
   import cache_mem_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic                           push,
   input  wb_entry_t                      push_entry,
   input  logic                           pop,
   output wb_entry_t                      head,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   input  logic [ADDR_W-1:0]              search_addr,
   output logic                           hit,
   output logic [DATA_W-1:0]              hit_data
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   wb_entry_t        entries_reg [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;

   // Pointers wrap modulo DEPTH, which need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (int'(p) == DEPTH - 1) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   // Slot holding the k-th oldest entry.
   function automatic logic [PTR_W-1:0] slot_at(input logic [PTR_W-1:0] rd, input int k);
      return PTR_W'((int'(rd) + k) % DEPTH);
   endfunction

   // Entry storage carries no reset; only the pointers define what is live.
   always_ff @(posedge clock) begin
      if (push) begin
         entries_reg[wr_ptr_reg] <= push_entry;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         end
         if (pop) begin
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         end
         if (push && !pop) begin
            count_reg <= count_reg + 1'b1;
         end else if (pop && !push) begin
            count_reg <= count_reg - 1'b1;
         end
      end
   end

   // Scan oldest to newest so a later match overrides an earlier one; the
   // head is included even when it is popping this cycle.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (k < int'(count_reg)) begin
            if (entries_reg[slot_at(rd_ptr_reg, k)].addr == search_addr) begin
               hit      = 1'b1;
               hit_data = entries_reg[slot_at(rd_ptr_reg, k)].data;
            end
         end
      end
   end

   assign head  = entries_reg[rd_ptr_reg];
   assign full  = (count_reg == CNT_W'(DEPTH));
   assign empty = (count_reg == '0);
   assign count = count_reg;

endmodule

// File: rtl/cache_backing_mem.sv
// ----------------------------------------------------------------------------
// cache_backing_mem
// Backing-store responder for the 4-way set-associative cache. Serves fill
// reads with a fixed latency, absorbs dirty-victim write-backs into a small
// buffer that drains to the word array at a limited pace, and forwards
// buffered data to reads so a read always sees the newest value.
// Ports:
//   clock, reset_n : clock and synchronous active-low reset
//   req_valid/req_ready : request handshake (accepted when both high)
//   req_write      : 1 = write-back, 0 = fill read
//   req_addr       : word address {tag[2:0], index[1:0]}
//   req_data       : write-back data (unused for reads)
//   resp_valid     : one-cycle pulse with read data
//   resp_data      : read data, held until the next response
//   wb_count       : occupied write-back buffer entries
//   busy           : a read is outstanding
// ----------------------------------------------------------------------------
module cache_backing_mem
   import cache_mem_pkg::*;
#(
   parameter int READ_LATENCY = 3,
   parameter int WB_DEPTH     = 2,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic                             clock,
   input  logic                             reset_n,
   input  logic                             req_valid,
   output logic                             req_ready,
   input  logic                             req_write,
   input  logic [ADDR_W-1:0]                req_addr,
   input  logic [DATA_W-1:0]                req_data,
   output logic                             resp_valid,
   output logic [DATA_W-1:0]                resp_data,
   output logic [$clog2(WB_DEPTH+1)-1:0]    wb_count,
   output logic                             busy
);

   localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam int CNT_W  = $clog2(WB_DEPTH + 1);

   state_t            state_reg;
   logic [LAT_W-1:0]  lat_cnt_reg;
   logic [DATA_W-1:0] snap_reg;
   logic              resp_valid_reg;
   logic [DATA_W-1:0] resp_data_reg;
   logic [DCNT_W-1:0] drain_cnt_reg;

   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_hit;
   logic [DATA_W-1:0] fifo_hit_data;
   wb_entry_t         fifo_head;
   logic [CNT_W-1:0]  fifo_count;

   logic [DATA_W-1:0] mem_words [MEM_WORDS];
   logic [DATA_W-1:0] read_word;
   logic              rd_accept;
   logic              wr_accept;
   logic              drain_fire;

   // Fullness is taken from the registered count, so a same-cycle pop never
   // opens room for a push. Holding ready low in reset keeps every output 0.
   assign req_ready = reset_n && (state_reg == IDLE) && !fifo_full;
   assign rd_accept = req_valid && req_ready && !req_write;
   assign wr_accept = req_valid && req_ready &&  req_write;

   assign drain_fire = !fifo_empty && (drain_cnt_reg == DCNT_W'(DRAIN_CYCLES - 1));

   // Buffered data is newer than the array, including an entry retiring now.
   assign read_word = fifo_hit ? fifo_hit_data : mem_words[req_addr];

   wb_fifo #(
      .DEPTH (WB_DEPTH)
   ) u_wb_fifo (
      .clock       (clock),
      .reset_n     (reset_n),
      .push        (wr_accept),
      .push_entry  ({req_addr, req_data}),
      .pop         (drain_fire),
      .head        (fifo_head),
      .full        (fifo_full),
      .empty       (fifo_empty),
      .count       (fifo_count),
      .search_addr (req_addr),
      .hit         (fifo_hit),
      .hit_data    (fifo_hit_data)
   );

   // Word array: every word is reloaded with its fill pattern on reset, so it
   // is built from individual registers rather than a RAM macro.
   genvar gi;
   for (gi = 0; gi < MEM_WORDS; gi++) begin : g_word
      localparam logic [ADDR_W-1:0] WORD_ADDR = ADDR_W'(gi);
      logic [DATA_W-1:0] word_reg;

      always_ff @(posedge clock) begin
         if (!reset_n) begin
            word_reg <= fill_word(WORD_ADDR);
         end else if (drain_fire && (fifo_head.addr == WORD_ADDR)) begin
            word_reg <= fifo_head.data;
         end
      end

      assign mem_words[gi] = word_reg;
   end

   // Drain pacing: the head waits DRAIN_CYCLES cycles before retiring.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         drain_cnt_reg <= '0;
      end else if (fifo_empty || drain_fire) begin
         drain_cnt_reg <= '0;
      end else begin
         drain_cnt_reg <= drain_cnt_reg + 1'b1;
      end
   end

   // Read FSM. resp_valid is registered: it is raised on the edge that leaves
   // the latency counter at 0, so the pulse lines up with the final WAIT cycle.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         lat_cnt_reg    <= '0;
         snap_reg       <= '0;
         resp_valid_reg <= 1'b0;
         resp_data_reg  <= '0;
      end else begin
         resp_valid_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (rd_accept) begin
                  state_reg   <= WAIT;
                  lat_cnt_reg <= LAT_W'(READ_LATENCY - 1);
                  snap_reg    <= read_word;
                  if (READ_LATENCY == 1) begin
                     resp_valid_reg <= 1'b1;
                     resp_data_reg  <= read_word;
                  end
               end
            end
            WAIT: begin
               if (lat_cnt_reg == '0) begin
                  state_reg <= IDLE;
               end else begin
                  lat_cnt_reg <= lat_cnt_reg - 1'b1;
                  if (lat_cnt_reg == LAT_W'(1)) begin
                     resp_valid_reg <= 1'b1;
                     resp_data_reg  <= snap_reg;
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign resp_valid = resp_valid_reg;
   assign resp_data  = resp_data_reg;
   assign wb_count   = fifo_count;
   assign busy       = (state_reg == WAIT);

endmodule
